// File: rtl/yuv422_stream_converter.sv
// YUV 4:2:2 camera byte stream -> clamped {R,G,B} Avalon-ST source, one packet per frame.
// Pixel 0 valid 3 clks after a quad's last byte; ready=0 backs up into the FIFO, and pixels are dropped (overflow) when it is full.

module yuv422_sync_fifo #(
  parameter int W     = 26,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [W-1:0] wr_dat,
  input  logic         rd_en,
  output logic [W-1:0] rd_dat,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wr_dat;
  end

  // Extra pointer MSB tells a full ring from an empty one.
  assign rd_dat = mem_q[rd_ptr_q[AW-1:0]];
  assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty  = (wr_ptr_q == rd_ptr_q);
endmodule

module yuv422_stream_converter #(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int DW         = 24,
  parameter int FIFO_DEPTH = 16,
  parameter int BYTE_ORDER = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    cam_data,
  input  logic          cam_valid,
  input  logic          href,
  input  logic          vsync,
  input  logic          ready,
  output logic [DW-1:0] data,
  output logic          valid,
  output logic          startofpacket,
  output logic          endofpacket,
  output logic          empty,
  output logic          overflow,
  output logic          frame_error
);
  localparam int TOTAL = WIDTH * HEIGHT;
  localparam int CW    = $clog2(TOTAL);
  localparam logic [CW-1:0] CNT_LAST = CW'(TOTAL - 1);
  localparam logic [CW-1:0] CNT_ONE  = 1;

  function automatic logic [7:0] clamp8(input logic signed [10:0] v);
    if (v < 0)             return 8'd0;
    else if (v > 11'sd255) return 8'd255;
    else                   return v[7:0];
  endfunction

  function automatic logic [23:0] yuv2rgb(input logic [7:0] y, input logic [7:0] u,
                                          input logic [7:0] v);
    logic signed [10:0] c, d, e, r, g, b;
    c = $signed({3'b000, y}) - 11'sd16;
    d = $signed({3'b000, u}) - 11'sd128;
    e = $signed({3'b000, v}) - 11'sd128;
    r = c + e + (e >>> 2);
    g = c - e - (d >>> 2);
    b = c + (d <<< 2);
    return {clamp8(r), clamp8(g), clamp8(b)};
  endfunction

  logic [1:0]  phase_q, phase_d;
  logic [7:0]  b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;
  logic        byte_acc, quad_done;
  logic [7:0]  y0, y1, u, v;

  assign byte_acc  = cam_valid & href & ~vsync;
  assign quad_done = byte_acc && (phase_q == 2'd3);

  always_comb begin
    phase_d = phase_q;
    b0_d    = b0_q;
    b1_d    = b1_q;
    b2_d    = b2_q;
    if (!href || vsync) begin
      phase_d = 2'd0;
    end else if (cam_valid) begin
      phase_d = phase_q + 2'd1;
      case (phase_q)
        2'd0:    b0_d = cam_data;
        2'd1:    b1_d = cam_data;
        2'd2:    b2_d = cam_data;
        default: ;
      endcase
    end
  end

  assign y0 = (BYTE_ORDER == 0) ? b0_q : b1_q;
  assign u  = (BYTE_ORDER == 0) ? b1_q : b0_q;
  assign y1 = (BYTE_ORDER == 0) ? b2_q : cam_data;
  assign v  = (BYTE_ORDER == 0) ? cam_data : b2_q;

  // Pair register: both pixels land together, then drain one per cycle.
  logic [23:0] pix0_q, pix0_d, pix1_q, pix1_d;
  logic        p0_vld_q, p0_vld_d, p1_vld_q, p1_vld_d;

  always_comb begin
    pix0_d   = pix0_q;
    pix1_d   = pix1_q;
    p0_vld_d = p0_vld_q;
    p1_vld_d = p1_vld_q;
    if (vsync) begin
      p0_vld_d = 1'b0;
      p1_vld_d = 1'b0;
    end else if (quad_done) begin
      pix0_d   = yuv2rgb(y0, u, v);
      pix1_d   = yuv2rgb(y1, u, v);
      p0_vld_d = 1'b1;
      p1_vld_d = 1'b1;
    end else if (p0_vld_q) begin
      p0_vld_d = 1'b0;
    end else if (p1_vld_q) begin
      p1_vld_d = 1'b0;
    end
  end

  logic          pix_req, wr_take, px_sop, px_eop;
  logic [23:0]   pix_sel;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          hold_q, hold_d;
  logic          fifo_wr, fifo_rd, fifo_full, fifo_empty;
  logic [25:0]   fifo_rd_dat;
  logic          overflow_q, overflow_d;
  logic          vsync_q, frame_error_q, frame_error_d;

  assign pix_req = ~vsync & (p0_vld_q | p1_vld_q);
  assign pix_sel = p0_vld_q ? pix0_q : pix1_q;
  assign wr_take = pix_req & ~hold_q;
  assign px_sop  = (cnt_q == '0);
  assign px_eop  = (cnt_q == CNT_LAST);
  // A read in the same cycle frees a slot, so a full FIFO can still accept.
  assign fifo_wr = wr_take & (~fifo_full | fifo_rd);

  // hold_q starts set so nothing is framed until the first vsync.
  always_comb begin
    cnt_d  = cnt_q;
    hold_d = hold_q;
    if (vsync) begin
      cnt_d  = '0;
      hold_d = 1'b0;
    end else if (wr_take) begin
      if (px_eop) hold_d = 1'b1;
      else        cnt_d  = cnt_q + CNT_ONE;
    end
  end

  assign overflow_d    = overflow_q | (wr_take & fifo_full & ~fifo_rd);
  assign frame_error_d = vsync & ~vsync_q & (cnt_q != '0) & ~hold_q;

  yuv422_sync_fifo #(
    .W     (26),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (fifo_wr),
    .wr_dat ({px_eop, px_sop, pix_sel}),
    .rd_en  (fifo_rd),
    .rd_dat (fifo_rd_dat),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  logic        out_vld_q, out_vld_d;
  logic [25:0] out_dat_q, out_dat_d;

  assign fifo_rd = ~fifo_empty & (~out_vld_q | ready);

  always_comb begin
    out_vld_d = out_vld_q;
    out_dat_d = out_dat_q;
    if (fifo_rd) begin
      out_vld_d = 1'b1;
      out_dat_d = fifo_rd_dat;
    end else if (ready) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q       <= 2'd0;
      b0_q          <= '0;
      b1_q          <= '0;
      b2_q          <= '0;
      pix0_q        <= '0;
      pix1_q        <= '0;
      p0_vld_q      <= 1'b0;
      p1_vld_q      <= 1'b0;
      cnt_q         <= '0;
      hold_q        <= 1'b1;
      overflow_q    <= 1'b0;
      vsync_q       <= 1'b0;
      frame_error_q <= 1'b0;
      out_vld_q     <= 1'b0;
      out_dat_q     <= '0;
    end else begin
      phase_q       <= phase_d;
      b0_q          <= b0_d;
      b1_q          <= b1_d;
      b2_q          <= b2_d;
      pix0_q        <= pix0_d;
      pix1_q        <= pix1_d;
      p0_vld_q      <= p0_vld_d;
      p1_vld_q      <= p1_vld_d;
      cnt_q         <= cnt_d;
      hold_q        <= hold_d;
      overflow_q    <= overflow_d;
      vsync_q       <= vsync;
      frame_error_q <= frame_error_d;
      out_vld_q     <= out_vld_d;
      out_dat_q     <= out_dat_d;
    end
  end

  always_comb begin
    data       = '0;
    data[23:0] = out_dat_q[23:0];
  end

  assign valid         = out_vld_q;
  assign startofpacket = out_vld_q & out_dat_q[24];
  assign endofpacket   = out_vld_q & out_dat_q[25];
  assign empty         = 1'b0;
  assign overflow      = overflow_q;
  assign frame_error   = frame_error_q;
endmodule

// File: tb/tb_yuv422_stream_converter.sv
// Two converters (YUYV and UYVY) fed the same quads; a scoreboard checks both output streams.
module tb_yuv422_stream_converter;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam int DW = 24;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    cam_data0, cam_data1;
  logic          cam_valid, href, vsync, ready;
  logic [DW-1:0] data0, data1;
  logic          valid0, sop0, eop0, empty0, ovf0, fe0;
  logic          valid1, sop1, eop1, empty1, ovf1, fe1;

  always #5 clk = ~clk;

  yuv422_stream_converter #(.WIDTH(W), .HEIGHT(H), .DW(DW), .FIFO_DEPTH(FD), .BYTE_ORDER(0)) u_dut0 (
    .clk(clk), .reset(reset), .cam_data(cam_data0), .cam_valid(cam_valid), .href(href),
    .vsync(vsync), .ready(ready), .data(data0), .valid(valid0), .startofpacket(sop0),
    .endofpacket(eop0), .empty(empty0), .overflow(ovf0), .frame_error(fe0));

  yuv422_stream_converter #(.WIDTH(W), .HEIGHT(H), .DW(DW), .FIFO_DEPTH(FD), .BYTE_ORDER(1)) u_dut1 (
    .clk(clk), .reset(reset), .cam_data(cam_data1), .cam_valid(cam_valid), .href(href),
    .vsync(vsync), .ready(ready), .data(data1), .valid(valid1), .startofpacket(sop1),
    .endofpacket(eop1), .empty(empty1), .overflow(ovf1), .frame_error(fe1));

  int compared   = 0;
  int mismatched = 0;
  int fe_cnt0    = 0;
  int fe_cnt1    = 0;
  logic [25:0] q0[$];
  logic [25:0] q1[$];
  logic [25:0] exp0, exp1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && valid0 && ready) begin
      if (q0.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL yuyv unexpected pixel: got %0h, required none", {eop0, sop0, data0});
      end else begin
        exp0 = q0.pop_front();
        check("yuyv pixel {eop,sop,rgb}", {6'b0, eop0, sop0, data0}, {6'b0, exp0});
      end
    end
    if (!reset && fe0) fe_cnt0++;
  end

  always @(negedge clk) begin
    if (!reset && valid1 && ready) begin
      if (q1.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL uyvy unexpected pixel: got %0h, required none", {eop1, sop1, data1});
      end else begin
        exp1 = q1.pop_front();
        check("uyvy pixel {eop,sop,rgb}", {6'b0, eop1, sop1, data1}, {6'b0, exp1});
      end
    end
    if (!reset && fe1) fe_cnt1++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_px(input logic [23:0] rgb, input logic sop, input logic eop);
    q0.push_back({eop, sop, rgb});
    q1.push_back({eop, sop, rgb});
  endtask

  task automatic send_byte(input logic [7:0] byte_yuyv, input logic [7:0] byte_uyvy);
    cam_data0 = byte_yuyv;
    cam_data1 = byte_uyvy;
    cam_valid = 1'b1;
    href      = 1'b1;
    tick();
  endtask

  task automatic send_quad(input logic [7:0] y0, input logic [7:0] u,
                           input logic [7:0] y1, input logic [7:0] v);
    send_byte(y0, u);
    send_byte(u, y0);
    send_byte(y1, v);
    send_byte(v, y1);
  endtask

  task automatic end_line();
    cam_valid = 1'b0;
    href      = 1'b0;
    repeat (3) tick();
  endtask

  task automatic do_vsync();
    cam_valid = 1'b0;
    href      = 1'b0;
    vsync     = 1'b1;
    repeat (3) tick();
    vsync = 1'b0;
    repeat (2) tick();
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 300) begin
      tick();
      n++;
    end
    check({name, " pixels left undelivered"}, q0.size() + q1.size(), 0);
    repeat (6) tick();
  endtask

  initial begin
    reset = 1'b1; cam_data0 = '0; cam_data1 = '0; cam_valid = 1'b0;
    href = 1'b0; vsync = 1'b0; ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset valid",       valid0, 0);
    check("reset sop",         sop0, 0);
    check("reset eop",         eop0, 0);
    check("reset data",        data0, 0);
    check("reset overflow",    ovf0, 0);
    check("reset frame_error", fe0, 0);
    check("reset valid uyvy",  valid1, 0);
    reset = 1'b0;
    ready = 1'b1;
    begin
      int vcount = 0;
      repeat (100) begin
        tick();
        if (valid0 || valid1) vcount++;
      end
      check("idle cycles with valid", vcount, 0);
    end
    check("empty constant", empty0, 0);

    // A quad before any vsync must not be framed.
    send_quad(8'd16, 8'd128, 8'd16, 8'd128);
    end_line();
    repeat (8) tick();
    check("pre-vsync valid", valid0, 0);

    // Frame A: all-black frame.
    do_vsync();
    expect_px(24'h000000, 1'b1, 1'b0);
    for (int i = 1; i < 7; i++) expect_px(24'h000000, 1'b0, 1'b0);
    expect_px(24'h000000, 1'b0, 1'b1);
    for (int l = 0; l < H; l++) begin
      send_quad(8'd16, 8'd128, 8'd16, 8'd128);
      send_quad(8'd16, 8'd128, 8'd16, 8'd128);
      end_line();
    end
    wait_drain("frame A");
    check("frame A frame_error count", fe_cnt0, 0);

    // Frame B: clamp and colour values, plus a half quad at a line start.
    do_vsync();
    expect_px(24'hDBBCFF, 1'b1, 1'b0);
    expect_px(24'h7051FF, 1'b0, 1'b0);
    expect_px(24'h9E0000, 1'b0, 1'b0);
    expect_px(24'hFF9000, 1'b0, 1'b0);
    expect_px(24'hAE1300, 1'b0, 1'b0);
    expect_px(24'h7C0000, 1'b0, 1'b0);
    expect_px(24'h707070, 1'b0, 1'b0);
    expect_px(24'hEFEFEF, 1'b0, 1'b1);
    send_quad(8'd235, 8'd255, 8'd128, 8'd128);
    send_quad(8'd16, 8'd0, 8'd255, 8'd255);
    end_line();
    send_byte(8'd50, 8'd60);
    send_byte(8'd60, 8'd50);
    end_line();
    send_quad(8'd100, 8'd100, 8'd50, 8'd200);
    send_quad(8'd128, 8'd128, 8'd255, 8'd128);
    end_line();
    wait_drain("frame B");
    check("frame B frame_error count", fe_cnt0 + fe_cnt1, 0);
    check("overflow before stall", ovf0, 0);

    // Frame C: stall the sink so pixel 5 is dropped; EOP must stay on pixel 7.
    ready = 1'b0;
    do_vsync();
    expect_px(24'h101010, 1'b1, 1'b0);
    expect_px(24'h202020, 1'b0, 1'b0);
    expect_px(24'h303030, 1'b0, 1'b0);
    expect_px(24'h404040, 1'b0, 1'b0);
    expect_px(24'h505050, 1'b0, 1'b0);
    send_quad(8'd32, 8'd128, 8'd48, 8'd128);
    send_quad(8'd64, 8'd128, 8'd80, 8'd128);
    end_line();
    send_quad(8'd96, 8'd128, 8'd112, 8'd128);
    end_line();
    repeat (6) tick();
    check("stall overflow yuyv", ovf0, 1);
    check("stall overflow uyvy", ovf1, 1);
    check("stall valid held", valid0, 1);
    check("stall data held", data0, 32'h101010);
    check("stall sop held", sop0, 1);
    ready = 1'b1;
    wait_drain("frame C head");
    expect_px(24'h707070, 1'b0, 1'b0);
    expect_px(24'h808080, 1'b0, 1'b1);
    send_quad(8'd128, 8'd128, 8'd144, 8'd128);
    end_line();
    wait_drain("frame C tail");
    check("frame C frame_error count", fe_cnt0, 0);

    // Frame D: vsync after 3 of 8 pixels.
    do_vsync();
    expect_px(24'h0A0A0A, 1'b1, 1'b0);
    expect_px(24'h141414, 1'b0, 1'b0);
    expect_px(24'h1E1E1E, 1'b0, 1'b0);
    send_quad(8'd26, 8'd128, 8'd36, 8'd128);
    send_quad(8'd46, 8'd128, 8'd56, 8'd128);
    cam_valid = 1'b0;
    tick();
    href  = 1'b0;
    vsync = 1'b1;
    repeat (3) tick();
    vsync = 1'b0;
    repeat (2) tick();
    wait_drain("frame D");
    check("frame_error pulses yuyv", fe_cnt0, 1);
    check("frame_error pulses uyvy", fe_cnt1, 1);

    // Frame E: framing restarts cleanly after the aborted frame.
    expect_px(24'h202020, 1'b1, 1'b0);
    for (int i = 1; i < 7; i++) expect_px(24'h000000, 1'b0, 1'b0);
    expect_px(24'h000000, 1'b0, 1'b1);
    send_quad(8'd48, 8'd128, 8'd16, 8'd128);
    send_quad(8'd16, 8'd128, 8'd16, 8'd128);
    end_line();
    send_quad(8'd16, 8'd128, 8'd16, 8'd128);
    send_quad(8'd16, 8'd128, 8'd16, 8'd128);
    end_line();
    wait_drain("frame E");
    check("frame E frame_error count", fe_cnt0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
